// File: rtl/rs232_rx_ctrl.sv
// RS-232 receive controller: mid-bit sampling, 8N1 byte assembly LSB first,
// framing-error detection. Started by a one-cycle pulse from the RX start detector.
module rs232_rx_ctrl #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_ref,
    input  logic       rst_n,
    input  logic       i_rx_start_en,
    input  logic       i_rx_pin,
    output logic       o_rs232_busy,
    output logic [3:0] o_ctrl_cnt,
    output logic [7:0] o_rx_dat,
    output logic       o_rx_vld,
    output logic       o_frame_err
);

    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC);
    localparam logic [CNT_W-1:0] SAMPLE_AT   = CNT_W'(HALF_CYC - 1);
    localparam logic [CNT_W-1:0] BOUNDARY_AT = CNT_W'(BIT_CYC - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    state_t           next_state;
    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] baud_cnt;
    logic             sample;
    logic             boundary;
    logic [7:0]       shift;

    // Synchroniser flops reset to the idle line level so no false start follows reset.
    // NOTE: sequential state is always assigned with <=; blocking = here would race.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= i_rx_pin;
            sync2 <= sync1;
        end
    end

    assign sample   = (baud_cnt == SAMPLE_AT);
    assign boundary = (baud_cnt == BOUNDARY_AT);

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (i_rx_start_en) next_state = START;
            START: begin
                if (sample && sync2) next_state = IDLE;
                else if (boundary)   next_state = DATA;
            end
            DATA:  if (boundary && o_ctrl_cnt == 4'd8) next_state = STOP;
            STOP:  if (sample) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        o_rs232_busy = 1'b0;
        if (state != IDLE) o_rs232_busy = 1'b1;
    end

    // Counter is held at zero in IDLE, which also clears it on IDLE->START.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n)                                 baud_cnt <= '0;
        else if (state == IDLE || next_state == IDLE) baud_cnt <= '0;
        else if (boundary)                          baud_cnt <= '0;
        else                                        baud_cnt <= baud_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n)                                           o_ctrl_cnt <= 4'd0;
        else if (next_state == IDLE)                          o_ctrl_cnt <= 4'd0;
        else if ((state == START || state == DATA) && boundary) o_ctrl_cnt <= o_ctrl_cnt + 4'd1;
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n)                       shift <= 8'h00;
        else if (state == DATA && sample) shift <= {sync2, shift[7:1]};
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            o_rx_dat    <= 8'h00;
            o_rx_vld    <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_vld    <= (state == STOP) && sample && sync2;
            o_frame_err <= (state == STOP) && sample && !sync2;
            if (state == STOP && sample && sync2) o_rx_dat <= shift;
        end
    end

endmodule
